// File: rtl/psum_writeback.sv
// Partial-sum writeback: bias add, optional ReLU, round/saturate, and buffered
// sequential writes of one ofmap frame into the global buffer.
module psum_writeback #(
    parameter int unsigned G_BUF_ADDR_WIDTH = 10,
    parameter int unsigned G_BUF_DATA_WIDTH = 8,
    parameter int unsigned G_TOP_BITS       = 2,
    parameter int unsigned G_BOT_BITS       = 14,
    parameter int unsigned G_OUT_FRAC_BITS  = 6,
    parameter int unsigned G_KERNEL_SIZE    = 5,
    parameter int unsigned G_IMAGE_HEIGHT   = 28,
    parameter int unsigned G_IMAGE_WIDTH    = 28,
    parameter int unsigned G_FIFO_DEPTH     = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic [G_BUF_ADDR_WIDTH-1:0]          base_addr_i,
    input  logic [G_TOP_BITS+G_BOT_BITS-1:0]     bias_i,
    input  logic                                 relu_en_i,
    input  logic                                 psum_vld_i,
    input  logic [G_TOP_BITS+G_BOT_BITS-1:0]     psum_i,
    output logic                                 buf_wr_en_o,
    input  logic                                 buf_wr_rdy_i,
    output logic [G_BUF_ADDR_WIDTH-1:0]          buf_addr_o,
    output logic [G_BUF_DATA_WIDTH-1:0]          buf_data_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 overflow_o
);

    localparam int unsigned AW     = G_BUF_ADDR_WIDTH;
    localparam int unsigned DW     = G_BUF_DATA_WIDTH;
    localparam int unsigned PSUM_W = G_TOP_BITS + G_BOT_BITS;
    localparam int unsigned SUM_W  = PSUM_W + 2;
    localparam int unsigned SH     = G_BOT_BITS - G_OUT_FRAC_BITS;
    localparam int unsigned HALF   = (SH > 0) ? (1 << (SH - 1)) : 0;
    localparam int unsigned N_OUT  = (G_IMAGE_HEIGHT - G_KERNEL_SIZE + 1) *
                                     (G_IMAGE_WIDTH - G_KERNEL_SIZE + 1);
    localparam int unsigned CNT_W  = $clog2(N_OUT + 1);
    localparam int unsigned PTR_W  = $clog2(G_FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned ENT_W  = AW + DW;

    localparam logic signed [SUM_W-1:0] U_MAX = SUM_W'((1 << DW) - 1);
    localparam logic signed [SUM_W-1:0] S_MAX = SUM_W'((1 << (DW - 1)) - 1);
    localparam logic signed [SUM_W-1:0] S_MIN = ~S_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]          wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]             base_q, base_d;
    logic signed [PSUM_W-1:0]  bias_q, bias_d;
    logic                      relu_q, relu_d;
    logic                      ovf_q, ovf_d;
    logic                      done_q, done_d;
    logic                      busy_q;

    logic [ENT_W-1:0]          fifo_mem [G_FIFO_DEPTH];
    logic [PTR_W-1:0]          wptr_q, rptr_q;
    logic [OCC_W-1:0]          occ_q;
    logic [ENT_W-1:0]          head_c;

    logic                      fifo_empty_c, fifo_full_c;
    logic                      accept_c, pop_c, push_c, drop_c;
    logic signed [SUM_W-1:0]   sum_c, rsum_c, rnd_c;
    logic [DW-1:0]             q_c;
    logic [AW-1:0]             pix_addr_c;

    assign fifo_empty_c = (occ_q == '0);
    assign fifo_full_c  = (occ_q == OCC_W'(G_FIFO_DEPTH));
    assign accept_c     = (state_q == ST_RUN) && psum_vld_i;
    assign pop_c        = !fifo_empty_c && buf_wr_rdy_i;
    // A full FIFO still takes the new word when the head leaves on the same edge.
    assign push_c       = accept_c && (!fifo_full_c || pop_c);
    assign drop_c       = accept_c && fifo_full_c && !pop_c;
    assign pix_addr_c   = base_q + AW'(in_cnt_q);

    // Bias, ReLU, round-half-up and saturate to the buffer word format.
    always_comb begin
        sum_c = SUM_W'(signed'(psum_i)) + SUM_W'(bias_q);
        if (relu_q && sum_c[SUM_W-1]) begin
            sum_c = '0;
        end
        rsum_c = sum_c + signed'(SUM_W'(HALF));
        rnd_c  = rsum_c >>> SH;
        q_c    = rnd_c[DW-1:0];
        if (relu_q) begin
            if (rnd_c > U_MAX) begin
                q_c = '1;
            end
        end else if (rnd_c > S_MAX) begin
            q_c = {1'b0, {(DW-1){1'b1}}};
        end else if (rnd_c < S_MIN) begin
            q_c = {1'b1, {(DW-1){1'b0}}};
        end
    end

    // Frame control: wr_cnt advances on every write and every dropped pixel.
    always_comb begin
        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        wr_cnt_d = wr_cnt_q;
        base_d   = base_q;
        bias_d   = bias_q;
        relu_d   = relu_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        if (pop_c || drop_c) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    base_d   = base_addr_i;
                    bias_d   = bias_i;
                    relu_d   = relu_en_i;
                    in_cnt_d = '0;
                    wr_cnt_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (drop_c) begin
                        ovf_d = 1'b1;
                    end
                    if (in_cnt_q == CNT_W'(N_OUT - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (wr_cnt_d == CNT_W'(N_OUT)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            in_cnt_q <= '0;
            wr_cnt_q <= '0;
            base_q   <= '0;
            bias_q   <= '0;
            relu_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            base_q   <= base_d;
            bias_q   <= bias_d;
            relu_q   <= relu_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    // Output FIFO; each entry carries its own address so dropped pixels leave holes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            for (int unsigned i = 0; i < G_FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push_c) begin
                fifo_mem[wptr_q] <= {pix_addr_c, q_c};
                wptr_q           <= wptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (pop_c && !push_c) begin
                occ_q <= occ_q - OCC_W'(1);
            end
        end
    end

    assign head_c      = fifo_mem[rptr_q];
    assign buf_wr_en_o = !fifo_empty_c;
    assign buf_addr_o  = fifo_empty_c ? '0 : head_c[ENT_W-1:DW];
    assign buf_data_o  = fifo_empty_c ? '0 : head_c[DW-1:0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Bench for psum_writeback: directed frames with random psums, checked against
// a queue-based reference of the quantize/write/drop rules.
module tb_psum_writeback;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int N_OUT = 576;
    localparam int SH    = 14 - 6;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [15:0]   bias_i;
    logic          relu_en_i;
    logic          psum_vld_i;
    logic [15:0]   psum_i;
    logic          buf_wr_en_o;
    logic          buf_wr_rdy_i;
    logic [AW-1:0] buf_addr_o;
    logic [DW-1:0] buf_data_o;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;

    psum_writeback dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .bias_i       (bias_i),
        .relu_en_i    (relu_en_i),
        .psum_vld_i   (psum_vld_i),
        .psum_i       (psum_i),
        .buf_wr_en_o  (buf_wr_en_o),
        .buf_wr_rdy_i (buf_wr_rdy_i),
        .buf_addr_o   (buf_addr_o),
        .buf_data_o   (buf_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // reference model state
    int            m_phase = P_IDLE;
    logic [AW-1:0] m_base;
    logic [15:0]   m_bias;
    bit            m_relu;
    int            m_in, m_wr, m_drops;
    bit            m_ovf, m_done;
    logic [AW+DW-1:0] m_q[$];

    int            done_seen, dut_writes;
    logic [AW-1:0] dut_last_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] quant(input logic [15:0] p, input logic [15:0] b, input bit relu);
        int s, r;
        s = int'($signed(p)) + int'($signed(b));
        if (relu && s < 0) s = 0;
        r = (SH > 0) ? ((s + (1 << (SH - 1))) >>> SH) : s;
        if (relu) begin
            if (r > (1 << DW) - 1) r = (1 << DW) - 1;
        end else begin
            if (r > (1 << (DW - 1)) - 1) r = (1 << (DW - 1)) - 1;
            if (r < -(1 << (DW - 1))) r = -(1 << (DW - 1));
        end
        return DW'(r);
    endfunction

    // Compare outputs at the falling edge, then advance the model by one clock.
    task automatic tick();
        bit pop;
        logic [AW+DW-1:0] ent;
        chk("wr_en", 32'(buf_wr_en_o), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            ent = m_q[0];
            chk("addr", 32'(buf_addr_o), 32'(ent[AW+DW-1:DW]));
            chk("data", 32'(buf_data_o), 32'(ent[DW-1:0]));
        end
        chk("busy", 32'(busy_o), 32'(m_phase != P_IDLE));
        chk("done", 32'(done_o), 32'(m_done));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        if (done_o === 1'b1) done_seen++;
        if (buf_wr_en_o === 1'b1 && buf_wr_rdy_i) begin
            dut_writes++;
            dut_last_addr = buf_addr_o;
        end

        pop = (m_q.size() != 0) && buf_wr_rdy_i;
        if (pop) begin
            void'(m_q.pop_front());
            m_wr++;
        end
        m_done = 1'b0;
        case (m_phase)
            P_IDLE: if (start_i) begin
                m_phase = P_RUN;
                m_base  = base_addr_i;
                m_bias  = bias_i;
                m_relu  = relu_en_i;
                m_in    = 0;
                m_wr    = 0;
                m_ovf   = 1'b0;
            end
            P_RUN: if (psum_vld_i) begin
                ent = {m_base + AW'(m_in), quant(psum_i, m_bias, m_relu)};
                if (m_q.size() == DEPTH) begin
                    m_ovf = 1'b1;
                    m_wr++;
                    m_drops++;
                end else begin
                    m_q.push_back(ent);
                end
                m_in++;
                if (m_in == N_OUT) m_phase = P_DRAIN;
            end
            P_DRAIN: if (m_wr == N_OUT) begin
                m_phase = P_IDLE;
                m_done  = 1'b1;
            end
            default: ;
        endcase
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic pix(input logic [15:0] p, input bit rdy);
        psum_i       = p;
        psum_vld_i   = 1'b1;
        buf_wr_rdy_i = rdy;
        tick();
        psum_vld_i   = 1'b0;
    endtask

    task automatic start_frame(input logic [AW-1:0] base, input logic [15:0] bias, input bit relu);
        done_seen   = 0;
        dut_writes  = 0;
        m_drops     = 0;
        base_addr_i = base;
        bias_i      = bias;
        relu_en_i   = relu;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic run_pixels(input int n, input int max_gap, input int rdy_pct);
        for (int i = 0; i < n; i++) begin
            pix(16'($urandom), ($urandom_range(0, 99) < rdy_pct));
            repeat ($urandom_range(0, max_gap)) begin
                buf_wr_rdy_i = ($urandom_range(0, 99) < rdy_pct);
                tick();
            end
        end
    endtask

    task automatic end_frame(input string tag);
        psum_vld_i   = 1'b0;
        buf_wr_rdy_i = 1'b1;
        for (int i = 0; i < 100 && m_phase != P_IDLE; i++) tick();
        tick();
        tick();
        chk({tag, "_done_pulses"}, 32'(done_seen), 32'd1);
        chk({tag, "_writes"}, 32'(dut_writes), 32'(N_OUT - m_drops));
    endtask

    logic [15:0]   a_ps[5]   = '{16'h4000, 16'hC000, 16'h7FFF, 16'h0080, 16'h0180};
    logic [DW-1:0] a_dat[5]  = '{8'h40, 8'hC0, 8'h7F, 8'h01, 8'h02};
    logic [AW-1:0] a_adr[5]  = '{10'h3FF, 10'h000, 10'h001, 10'h002, 10'h003};
    logic [15:0]   b_ps[3]   = '{16'hE000, 16'h2000, 16'h7FFF};
    logic [DW-1:0] b_dat[3]  = '{8'h00, 8'h30, 8'h90};

    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        base_addr_i  = '0;
        bias_i       = '0;
        relu_en_i    = 1'b0;
        psum_vld_i   = 1'b0;
        psum_i       = '0;
        buf_wr_rdy_i = 1'b1;
        repeat (2) @(negedge clk_i);

        chk("rst_wr_en", 32'(buf_wr_en_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        chk("rst_addr", 32'(buf_addr_o), 32'd0);
        chk("rst_data", 32'(buf_data_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        tick();

        // psums while idle are ignored
        for (int i = 0; i < 3; i++) pix(16'($urandom), 1'b1);
        tick();

        // Frame A: signed output, wrap from 0x3FF, directed quantize values
        start_frame(10'h3FF, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            pix(a_ps[i], 1'b1);
            chk("A_dir_data", 32'(buf_data_o), 32'(a_dat[i]));
            chk("A_dir_addr", 32'(buf_addr_o), 32'(a_adr[i]));
        end
        base_addr_i = 10'h123;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        run_pixels(N_OUT - 5, 2, 80);
        end_frame("A");

        // Frame B: ReLU + bias, then 10 cycles of backpressure under back-to-back psums
        start_frame(10'h200, 16'h1000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            pix(b_ps[i], 1'b1);
            chk("B_dir_data", 32'(buf_data_o), 32'(b_dat[i]));
        end
        buf_wr_rdy_i = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) pix(16'($urandom), 1'b0);
        chk("B_overflow_set", 32'(overflow_o), 32'd1);
        chk("B_head_addr", 32'(buf_addr_o), 32'h203);
        run_pixels(N_OUT - 13, 0, 100);
        end_frame("B");
        chk("B_writes_after_drops", 32'(dut_writes), 32'd570);
        chk("B_overflow_sticky", 32'(overflow_o), 32'd1);

        // Frame C: base 0x100, one psum every 6 cycles, unsigned saturation
        start_frame(10'h100, 16'h7FFF, 1'b1);
        pix(16'h7FFF, 1'b1);
        chk("C_sat_data", 32'(buf_data_o), 32'hFF);
        chk("C_first_addr", 32'(buf_addr_o), 32'h100);
        repeat (5) tick();
        for (int i = 0; i < N_OUT - 1; i++) begin
            pix(16'($urandom), 1'b1);
            repeat (5) tick();
        end
        end_frame("C");
        chk("C_last_addr", 32'(dut_last_addr), 32'h33F);
        chk("C_overflow_clear", 32'(overflow_o), 32'd0);

        // Frame D: reset in the middle of a frame with a full FIFO
        start_frame(10'h050, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++) pix(16'($urandom), 1'b0);
        chk("D_overflow_pre", 32'(overflow_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("D_rst_busy", 32'(busy_o), 32'd0);
        chk("D_rst_wr_en", 32'(buf_wr_en_o), 32'd0);
        chk("D_rst_overflow", 32'(overflow_o), 32'd0);
        chk("D_rst_done", 32'(done_o), 32'd0);
        m_q.delete();
        m_phase = P_IDLE;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        @(negedge clk_i);
        done_seen    = 0;
        buf_wr_rdy_i = 1'b1;
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (6) tick();
        chk("D_no_done", 32'(done_seen), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
